spi_sphere_frame_receiver: RTL
==============================

Name: spi_sphere_frame_receiver

Overview:
- Sits between the SPI slave byte receiver and the raytracing controller; it is the producer end of the controller's `recv_dv` / `recv_64bit` / `recv_interrupt` interface.
- Assembles sync-prefixed 8-byte frames from the SPI byte stream into 64-bit sphere words (MSB byte first) and holds one word.
- Releases that word to the controller only while the controller requests one.
- Returns a one-byte status (ACK/NAK/ERR) to the SPI transmitter for each frame.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 100000, maximum idle clocks between payload bytes before the frame is aborted (1 ms at 100 MHz).
- ACK_BYTE, 8'h06, status: frame accepted.
- NAK_BYTE, 8'h15, status: frame dropped because the holding register was full.
- ERR_BYTE, 8'hE0, status: frame aborted by timeout.

Ports:
- CLK100MHZ  in  1  system clock.
- ck_rst  in  1  asynchronous, active-high reset.
- rx_dv  in  1  one-cycle strobe, `rx_byte` valid.
- rx_byte  in  8  byte from SPI slave.
- recv_interrupt  in  1  level from the controller; high = ready for the next sphere word.
- recv_dv  out  1  one-cycle strobe; `recv_64bit` is valid this cycle.
- recv_64bit  out  64  sphere word; registered and held until the next delivery.
- tran_dv  out  1  one-cycle strobe, `tran_byte` valid.
- tran_byte  out  8  status byte to SPI transmitter.
- word_pending  out  1  holding register occupied.
- overflow_count  out  8  saturating count of NAKed frames.

Behaviour:
Reset (async assert, sync release):
- All outputs are 0.
- FSM is in HUNT.
- Holding register is 0 and invalid.
- Byte index is 0; timeout counter is 0.

Assembler FSM (states HUNT, PAYLOAD):
- HUNT: `rx_dv` with `rx_byte` == SYNC_BYTE -> PAYLOAD, index = 0, timer = 0. Any other byte is discarded silently and produces no status.
- PAYLOAD, `rx_dv`: shift the byte into the assembly register (first byte lands in [63:56]), index++, timer = 0.
  - SYNC_BYTE inside the payload is data, not a resync.
- PAYLOAD, 8th byte accepted:
  - Holding register invalid (or being emptied this same cycle by delivery) -> load it with the assembled word, set valid, emit ACK_BYTE.
  - Otherwise -> drop the word, emit NAK_BYTE, overflow_count++ (saturates at 255).
  - In both cases -> HUNT.
- PAYLOAD, no `rx_dv`: timer++. When timer == TIMEOUT_CYCLES-1 -> emit ERR_BYTE, discard the partial word, -> HUNT.
  - If `rx_dv` arrives on the same cycle the timer expires, the byte wins and the timer resets.

Status output:
- `tran_dv` pulses exactly one cycle, the cycle after the triggering event.
- `tran_byte` is registered and held until the next status byte.
- At most one status per frame.

Delivery:
- Condition: holding register valid AND `recv_interrupt` high.
- Next cycle: `recv_64bit` <= holding register, `recv_dv` = 1 for one cycle, valid cleared.
- One word per request edge: after a delivery, no further delivery occurs until `recv_interrupt` has been seen low for at least one cycle. This prevents two words being pushed into one controller READY window.
- Delivery and frame completion in the same cycle: the old word is delivered, the new word is loaded, and valid stays 1 with ACK emitted.
- `recv_interrupt` dropping while valid: the word is retained; there is no timeout on the holding register.

Latency:
- 8th payload byte `rx_dv` -> `tran_dv` (ACK): 1 cycle.
- 8th payload byte `rx_dv` -> `recv_dv`: 2 cycles minimum, when `recv_interrupt` is already high and armed.

Reset mid-frame: the partial word is lost and no status is emitted after release.

`word_pending` mirrors the valid flag.

Decomposition:
- Shared package, alongside the existing shared type definitions:
  - sphere word width (64) and payload byte count (8);
  - SPI status byte constants (ACK/NAK/ERR/SYNC);
  - a frame-state enum.
- One natural sub-module: `spi_byte_timeout` (loadable down-counter with expire strobe), reusable by the future SPI transmit path.
- The holding register and delivery logic stay in the top module.

Test Plan:
- A5,01,02,03,04,05,06,07,08 with `recv_interrupt`=1 -> `tran_byte`=06 one cycle after the last byte; `recv_dv` pulse with `recv_64bit`=64'h0102030405060708 two cycles after the last byte.
- Frame with `recv_interrupt`=0, then a second frame -> first ACK, second NAK (15); `overflow_count`=1. Then raise `recv_interrupt` -> first word delivered once; `word_pending`=0.
- A5,11,22,33 then no bytes for 100000 cycles -> `tran_byte`=E0. Next valid frame decodes correctly.
- Junk bytes 00,FF,12 then A5 + payload containing A5 -> no status for the junk; the word contains the 8'hA5 byte at its position.
- `recv_interrupt` held high across two back-to-back frames -> only one `recv_dv`. Toggle `recv_interrupt` low then high -> the second word is delivered.
- Assert `ck_rst` after 4 payload bytes, release, send a full frame -> no ERR emitted; ACK and the correct word result.

Source files
------------

// File: rtl/spi_sphere_frame_receiver_pkg.sv
// rtl/spi_sphere_frame_receiver_pkg.sv - shared sphere-frame widths, SPI status bytes and frame state type
package spi_sphere_frame_receiver_pkg;

  localparam int SPHERE_WORD_W = 64;
  localparam int PAYLOAD_BYTES = 8;
  localparam int BYTE_IDX_W    = $clog2(PAYLOAD_BYTES);

  localparam logic [7:0] SPI_SYNC_BYTE = 8'hA5;
  localparam logic [7:0] SPI_ACK_BYTE  = 8'h06;
  localparam logic [7:0] SPI_NAK_BYTE  = 8'h15;
  localparam logic [7:0] SPI_ERR_BYTE  = 8'hE0;

  typedef enum logic {
    FRAME_HUNT    = 1'b0,
    FRAME_PAYLOAD = 1'b1
  } frame_state_t;

  // Increment that sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/spi_byte_timeout.sv
// rtl/spi_byte_timeout.sv - loadable down-counter that strobes expire when it runs out while enabled
module spi_byte_timeout #(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             expire
);

  logic [WIDTH-1:0] count;

  // Load wins over counting; the count parks at zero once exhausted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expire = enable && !load && (count == '0);

endmodule

// File: rtl/spi_sphere_frame_receiver.sv
// rtl/spi_sphere_frame_receiver.sv - assembles sync-prefixed SPI frames into sphere words and hands them to the controller
module spi_sphere_frame_receiver
  import spi_sphere_frame_receiver_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = SPI_SYNC_BYTE,
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter logic [7:0] ACK_BYTE       = SPI_ACK_BYTE,
  parameter logic [7:0] NAK_BYTE       = SPI_NAK_BYTE,
  parameter logic [7:0] ERR_BYTE       = SPI_ERR_BYTE
) (
  input  logic                     CLK100MHZ,
  input  logic                     ck_rst,
  input  logic                     rx_dv,
  input  logic [7:0]               rx_byte,
  input  logic                     recv_interrupt,
  output logic                     recv_dv,
  output logic [SPHERE_WORD_W-1:0] recv_64bit,
  output logic                     tran_dv,
  output logic [7:0]               tran_byte,
  output logic                     word_pending,
  output logic [7:0]               overflow_count
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  frame_state_t             state, state_next;
  logic [BYTE_IDX_W-1:0]    byte_idx;
  logic [SPHERE_WORD_W-1:0] asm_word;
  logic [SPHERE_WORD_W-1:0] full_word;
  logic [SPHERE_WORD_W-1:0] hold_word;
  logic                     hold_valid;
  logic                     armed;

  logic sync_seen;
  logic byte_in_payload;
  logic frame_done;
  logic timer_expire;
  logic deliver;
  logic accept;

  assign sync_seen       = (state == FRAME_HUNT) && rx_dv && (rx_byte == SYNC_BYTE);
  assign byte_in_payload = (state == FRAME_PAYLOAD) && rx_dv;
  assign frame_done      = byte_in_payload && (byte_idx == BYTE_IDX_W'(PAYLOAD_BYTES - 1));
  assign full_word       = {asm_word[SPHERE_WORD_W-9:0], rx_byte};

  // A word leaves only once per request: armed is re-set by seeing recv_interrupt low.
  assign deliver = hold_valid && recv_interrupt && armed;
  // A same-cycle delivery frees the slot for the frame completing now.
  assign accept  = frame_done && (!hold_valid || deliver);

  // Any accepted byte (sync or payload) restarts the inter-byte timer.
  spi_byte_timeout #(
    .WIDTH (TMR_W)
  ) u_timeout (
    .clk        (CLK100MHZ),
    .rst        (ck_rst),
    .load       (sync_seen || byte_in_payload),
    .load_value (TMR_W'(TIMEOUT_CYCLES - 1)),
    .enable     ((state == FRAME_PAYLOAD) && !rx_dv),
    .expire     (timer_expire)
  );

  // Frame state register.
  always_ff @(posedge CLK100MHZ or posedge ck_rst) begin
    if (ck_rst) state <= FRAME_HUNT;
    else        state <= state_next;
  end

  // Next frame state: hunt for sync, leave payload on completion or timeout.
  always_comb begin
    state_next = state;
    case (state)
      FRAME_HUNT:    if (sync_seen) state_next = FRAME_PAYLOAD;
      FRAME_PAYLOAD: if (frame_done || timer_expire) state_next = FRAME_HUNT;
      default:       state_next = FRAME_HUNT;
    endcase
  end

  // Payload assembly: MSB byte first, index restarts at each sync.
  always_ff @(posedge CLK100MHZ or posedge ck_rst) begin
    if (ck_rst) begin
      byte_idx <= '0;
      asm_word <= '0;
    end else if (sync_seen) begin
      byte_idx <= '0;
      asm_word <= '0;
    end else if (byte_in_payload) begin
      asm_word <= full_word;
      byte_idx <= frame_done ? '0 : byte_idx + 1'b1;
    end
  end

  // Holding register and one-word-per-request delivery to the controller.
  always_ff @(posedge CLK100MHZ or posedge ck_rst) begin
    if (ck_rst) begin
      hold_word  <= '0;
      hold_valid <= 1'b0;
      armed      <= 1'b1;
      recv_dv    <= 1'b0;
      recv_64bit <= '0;
    end else begin
      recv_dv <= deliver;
      if (deliver) begin
        recv_64bit <= hold_word;
        armed      <= 1'b0;
      end else if (!recv_interrupt) begin
        armed <= 1'b1;
      end
      if (accept) begin
        hold_word  <= full_word;
        hold_valid <= 1'b1;
      end else if (deliver) begin
        hold_valid <= 1'b0;
      end
    end
  end

  // Per-frame status byte back to the SPI transmitter, plus the NAK tally.
  always_ff @(posedge CLK100MHZ or posedge ck_rst) begin
    if (ck_rst) begin
      tran_dv        <= 1'b0;
      tran_byte      <= 8'h00;
      overflow_count <= 8'h00;
    end else begin
      tran_dv <= frame_done || timer_expire;
      if (frame_done) begin
        tran_byte <= accept ? ACK_BYTE : NAK_BYTE;
        if (!accept) overflow_count <= sat_inc8(overflow_count);
      end else if (timer_expire) begin
        tran_byte <= ERR_BYTE;
      end
    end
  end

  assign word_pending = hold_valid;

endmodule
